// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: LANES weighted synapses per beat, saturating lane accumulators.
// Optional per-beat leak is compiled in with `define NEURON_LEAK_EN.

module lif_lane #(
    parameter int BW   = 16,
    parameter int LEAK = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          syn,
    input  logic [BW-1:0] w,
    output logic [BW-1:0] acc
);
    logic [BW-1:0] base;
    logic [BW:0]   sum;
    logic [BW-1:0] nxt;

`ifdef NEURON_LEAK_EN
    localparam logic [BW-1:0] LEAK_W = BW'(LEAK);
    // Leak floors at zero before the new contribution is added.
    assign base = (acc > LEAK_W) ? acc - LEAK_W : '0;
`else
    assign base = acc;
`endif

    always_comb begin
        sum = {1'b0, base} + (syn ? {1'b0, w} : '0);
        nxt = sum[BW] ? '1 : sum[BW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= nxt;
    end
endmodule

module lif_neuron_core #(
    parameter int BW    = 16,
    parameter int LANES = 4,
    parameter int NIN   = 784,
    parameter int LEAK  = 0,
    localparam int CW   = $clog2(NIN + 1),
    localparam int TW   = BW + $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BW-1:0]       vth,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*BW-1:0] in_weight,
    input  logic [LANES-1:0]    in_syn,
    output logic                spk_valid,
    input  logic                spk_ready,
    output logic                spk_fire,
    output logic [CW-1:0]       spk_count,
    output logic [TW-1:0]       vmem,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, INTEG, REPORT} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              cnt;
    logic [BW-1:0]              vth_q;
    logic                       fire_q;
    logic [LANES-1:0][BW-1:0]   acc;
    logic [TW-1:0]              total;
    logic                       fire_now, done_now, beat, clr, take_start;

    always_comb begin
        total = '0;
        for (int i = 0; i < LANES; i++) total = total + TW'(acc[i]);
    end

    // Exit decisions use registered totals, so they trail the deciding beat by one cycle.
    assign fire_now   = total > TW'(vth_q);
    assign done_now   = cnt == CW'(NIN);
    assign take_start = (state == IDLE) && start;
    assign beat       = in_valid && in_ready;
    // A fired result clears on handshake; a non-fired one stays visible for inspection.
    assign clr        = take_start || ((state == REPORT) && spk_ready && fire_q);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lif_lane #(.BW(BW), .LEAK(LEAK)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (beat),
            .syn (in_syn[g]),
            .w   (in_weight[g*BW +: BW]),
            .acc (acc[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INTEG;
            INTEG:   if (fire_now || done_now) state_nxt = REPORT;
            REPORT:  if (spk_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == INTEG) && !fire_now && !done_now;
        spk_valid = state == REPORT;
        spk_fire  = (state == REPORT) && fire_q;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            vth_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            if (take_start) begin
                cnt    <= '0;
                vth_q  <= vth;
                fire_q <= 1'b0;
            end else if (beat) begin
                cnt <= cnt + CW'(LANES);
            end
            if ((state == INTEG) && (fire_now || done_now)) fire_q <= fire_now;
        end
    end

    assign spk_count = cnt;
    assign vmem      = total;
endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core; results are checked against a scoreboard queue of expected spikes.
module tb_lif_neuron_core;
    localparam int BW    = 16;
    localparam int LANES = 4;
    localparam int NIN   = 784;
`ifdef NEURON_LEAK_EN
    localparam int LEAK  = 10;
`else
    localparam int LEAK  = 0;
`endif
    localparam int CW = $clog2(NIN + 1);
    localparam int TW = BW + $clog2(LANES);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [BW-1:0]       vth = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*BW-1:0] in_weight = '0;
    logic [LANES-1:0]    in_syn = '0;
    logic                spk_valid;
    logic                spk_ready = 1'b0;
    logic                spk_fire;
    logic [CW-1:0]       spk_count;
    logic [TW-1:0]       vmem;
    logic                busy;

    typedef struct {
        logic fire;
        int   count;
        int   vmem;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    lif_neuron_core #(.BW(BW), .LANES(LANES), .NIN(NIN), .LEAK(LEAK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vth       (vth),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_syn    (in_syn),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_fire  (spk_fire),
        .spk_count (spk_count),
        .vmem      (vmem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [BW-1:0] v);
        start = 1'b1;
        vth   = v;
        tick();
        start = 1'b0;
        vth   = $urandom;
    endtask

    task automatic beat(input logic [LANES-1:0] syn, input logic [LANES*BW-1:0] wv);
        int n = 0;
        in_valid  = 1'b1;
        in_syn    = syn;
        in_weight = wv;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        if (!in_ready) chk("beat_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        in_syn    = $urandom;
        in_weight = {$urandom, $urandom};
    endtask

    task automatic get_result(input string tag);
        exp_t e;
        int n = 0;
        while (!spk_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, spk_valid, 1);
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_fire"},  spk_fire,  e.fire);
            chk({tag, "_count"}, spk_count, e.count);
            chk({tag, "_vmem"},  vmem,      e.vmem);
        end
    endtask

    task automatic handshake();
        spk_ready = 1'b1;
        tick();
        spk_ready = 1'b0;
    endtask

    task automatic run_main(input string tag);
        do_start(16'd1140);
        sbq.push_back('{1'b1, 12, 1200});
        for (int k = 1; k <= 3; k++) begin
            beat(4'hF, {4{16'd100}});
            chk({tag, "_total"}, vmem, 400 * k);
            chk({tag, "_cnt"},   spk_count, 4 * k);
        end
        chk({tag, "_ready_low"}, in_ready, 0);
        get_result(tag);
        chk({tag, "_ready_rep"}, in_ready, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", spk_valid, 0);
        chk("rst_fire",  spk_fire, 0);
        chk("rst_count", spk_count, 0);
        chk("rst_vmem",  vmem, 0);
        chk("rst_busy",  busy, 0);
        rst = 1'b1;
        tick();

        // Beats offered while idle must be refused.
        in_valid  = 1'b1;
        in_syn    = '1;
        in_weight = {4{16'd500}};
        chk("idle_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("idle_vmem", vmem, 0);

`ifdef NEURON_LEAK_EN
        do_start(16'd250);
        sbq.push_back('{1'b1, 12, 280});
        for (int k = 0; k < 3; k++) begin
            beat(4'b0001, {48'hFFFF_FFFF_FFFF, 16'd100});
            chk("leak_total", vmem, (k == 0) ? 100 : (k == 1) ? 190 : 280);
        end
        get_result("leak");
        handshake();
        chk("leak_busy", busy, 0);
`else
        run_main("fire");

        // Hold off the result with a start pulse that must be ignored.
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            vth   = 16'd7;
            tick();
            chk("hold_valid", spk_valid, 1);
            chk("hold_fire",  spk_fire, 1);
            chk("hold_count", spk_count, 12);
            chk("hold_vmem",  vmem, 1200);
        end
        start     = 1'b1;
        spk_ready = 1'b1;
        tick();
        start     = 1'b0;
        spk_ready = 1'b0;
        chk("hs_busy",  busy, 0);
        chk("hs_valid", spk_valid, 0);
        chk("hs_vmem",  vmem, 0);
        tick();
        chk("hs_busy2", busy, 0);

        do_start(16'd1140);
        sbq.push_back('{1'b0, 784, 0});
        for (int k = 0; k < 196; k++) beat(4'h0, {$urandom, $urandom});
        get_result("nosyn");
        handshake();
        chk("nosyn_busy", busy, 0);

        do_start(16'hFFFF);
        sbq.push_back('{1'b0, 784, 65535});
        beat(4'b0001, {48'hFFFF_FFFF_FFFF, 16'd40000});
        chk("sat_b1", vmem, 40000);
        beat(4'b0001, {48'hFFFF_FFFF_FFFF, 16'd40000});
        chk("sat_b2", vmem, 65535);
        for (int k = 0; k < 194; k++) beat(4'h0, {$urandom, $urandom});
        get_result("sat");
        handshake();
        chk("sat_keep_vmem",  vmem, 65535);
        chk("sat_keep_count", spk_count, 784);
        chk("sat_busy",       busy, 0);

        do_start(16'd1140);
        for (int k = 0; k < 10; k++) beat(4'hF, {4{16'd1}});
        chk("mid_vmem", vmem, 40);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_valid", spk_valid, 0);
        chk("mid_rst_fire",  spk_fire, 0);
        chk("mid_rst_count", spk_count, 0);
        chk("mid_rst_vmem",  vmem, 0);
        chk("mid_rst_busy",  busy, 0);
        #1;
        rst = 1'b1;
        tick();
        run_main("rerun");
        handshake();
        chk("rerun_busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
